// File: rtl/adder_measure_pkg.sv
// Shared types and default sizes for the adder measurement controller.
package adder_measure_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_WIN_W  = 16;
  localparam int DEFAULT_SETTLE = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

endpackage

// File: rtl/adder_measure_ctrl.sv
// Measurement initiator for the instrumented ripple adder: load, timed ring window, settle, capture.
// Optional build macro ADDER_MEASURE_SELFCHECK_EN adds a 'mismatch' output comparing the sum to a+b.
module adder_measure_ctrl
  import adder_measure_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int WIN_W         = DEFAULT_WIN_W,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] ring_sel,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic [WIDTH-1:0] adder_ring,
  output logic             adder_run,
  output logic             adder_clr,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic [WIDTH-1:0] adder_count,
  output state_t           state_dbg
`ifdef ADDER_MEASURE_SELFCHECK_EN
  ,
  output logic             mismatch
`endif
);

  // Handshake: start is honoured only in IDLE; busy spans accept..done, done is a
  // single-cycle pulse and results stay valid until the next capture.

  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] ONE         = WIN_W'(1);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic             accept, capture;

  logic [WIDTH-1:0] op_a_q, op_b_q, ring_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One down-counter times both the ring window and the settle interval.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = LOAD;
          cnt_d   = window;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q - ONE;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latches double as the adder drive, so they change only when LOAD begins.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      ring_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      count_out <= '0;
    end else begin
      done <= capture;
      if (accept) begin
        op_a_q <= op_a;
        op_b_q <= op_b;
        ring_q <= ring_sel;
        busy   <= 1'b1;
      end else if (capture) begin
        busy <= 1'b0;
      end
      if (capture) begin
        sum_out   <= adder_sum;
        count_out <= adder_count;
      end
    end
  end

`ifdef ADDER_MEASURE_SELFCHECK_EN
  logic [WIDTH-1:0] ref_sum;
  assign ref_sum = op_a_q + op_b_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mismatch <= 1'b0;
    end else if (capture) begin
      mismatch <= (adder_sum != ref_sum);
    end
  end
`endif

  // Decoded from the state register so an async reset drops them immediately.
  assign adder_run  = (state_q == RUN);
  assign adder_clr  = (state_q == LOAD);
  assign adder_a    = op_a_q;
  assign adder_b    = op_b_q;
  assign adder_ring = ring_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Directed and randomized bench for adder_measure_ctrl with a stub adder driven by the bench.
module tb_adder_measure_ctrl;
  import adder_measure_pkg::*;

  localparam int WIDTH  = 32;
  localparam int WIN_W  = 16;
  localparam int SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0, ring_sel = '0;
  logic [WIN_W-1:0] window = '0;
  logic             busy, done, adder_run, adder_clr;
  logic [WIDTH-1:0] sum_out, count_out, adder_a, adder_b, adder_ring;
  logic [WIDTH-1:0] adder_sum = '0, adder_count = '0;
  state_t           state_dbg;
`ifdef ADDER_MEASURE_SELFCHECK_EN
  logic             mismatch;
`endif

  int tests = 0;
  int fails = 0;

  adder_measure_ctrl #(.WIDTH(WIDTH), .WIN_W(WIN_W), .SETTLE_CYCLES(SETTLE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .ring_sel   (ring_sel),
    .window     (window),
    .busy       (busy),
    .done       (done),
    .sum_out    (sum_out),
    .count_out  (count_out),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_ring (adder_ring),
    .adder_run  (adder_run),
    .adder_clr  (adder_clr),
    .adder_sum  (adder_sum),
    .adder_count(adder_count),
    .state_dbg  (state_dbg)
`ifdef ADDER_MEASURE_SELFCHECK_EN
    ,
    .mismatch   (mismatch)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] ring, input int win,
                        input logic [WIDTH-1:0] ssum, input logic [WIDTH-1:0] scnt);
    op_a        = a;
    op_b        = b;
    ring_sel    = ring;
    window      = WIN_W'(win);
    adder_sum   = ssum;
    adder_count = scnt;
    start       = 1'b1;
  endtask

  // Follows one measurement from the accepting edge to done; n counts cycles after start.
  task automatic wait_done(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] ring, input int win,
                           input logic [WIDTH-1:0] ssum, input logic [WIDTH-1:0] scnt,
                           input bit spam, input bit keep);
    int n = 0, runs = 0, clrs = 0;
    bit seen = 0;
    while (!seen && n < win + 40) begin
      @(negedge clk);
      n++;
      if (adder_run) runs++;
      if (adder_clr) clrs++;
      if (n == 1) begin
        check({tag, "_load_clr"}, 64'(adder_clr), 64'(1));
        check({tag, "_load_a"}, 64'(adder_a), 64'(a));
        check({tag, "_busy"}, 64'(busy), 64'(1));
      end
      if (done) seen = 1;
      else if (spam) begin
        start    = 1'b1;
        op_a     = $urandom;
        op_b     = $urandom;
        ring_sel = $urandom;
        window   = WIN_W'($urandom_range(0, 50));
      end else start = 1'b0;
    end
    if (seen) start = keep;
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    check({tag, "_latency"}, 64'(n), 64'(win + SETTLE + 3));
    check({tag, "_run_cycles"}, 64'(runs), 64'(win));
    check({tag, "_clr_pulses"}, 64'(clrs), 64'(1));
    check({tag, "_sum"}, 64'(sum_out), 64'(ssum));
    check({tag, "_count"}, 64'(count_out), 64'(scnt));
    check({tag, "_hold_a"}, 64'(adder_a), 64'(a));
    check({tag, "_hold_b"}, 64'(adder_b), 64'(b));
    check({tag, "_hold_ring"}, 64'(adder_ring), 64'(ring));
    check({tag, "_busy_low"}, 64'(busy), 64'(0));
`ifdef ADDER_MEASURE_SELFCHECK_EN
    check({tag, "_mismatch"}, 64'(mismatch), 64'(ssum != WIDTH'(a + b)));
`endif
  endtask

  initial begin
    int extra;
    logic [WIDTH-1:0] ra, rb, rr, rs, rc;
    int rw;

    // Reset state
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_run", 64'(adder_run), 64'(0));
    check("rst_clr", 64'(adder_clr), 64'(0));
    check("rst_sum", 64'(sum_out), 64'(0));
    check("rst_count", 64'(count_out), 64'(0));
    check("rst_a", 64'(adder_a), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(IDLE));
`ifdef ADDER_MEASURE_SELFCHECK_EN
    check("rst_mismatch", 64'(mismatch), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-RUN: run and busy drop without a clock edge, no done afterwards
    @(negedge clk);
    launch(32'h11, 32'h22, 32'h3, 100, 32'h33, 32'h99);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrun_run_before", 64'(adder_run), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("midrun_run_async", 64'(adder_run), 64'(0));
    check("midrun_busy_async", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_state_idle", 64'(state_dbg), 64'(IDLE));
    extra = 0;
    repeat (120) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midrun_no_done", 64'(extra), 64'(0));
    check("midrun_sum_clear", 64'(sum_out), 64'(0));

    // Basic measurement, window=8
    @(negedge clk);
    launch(32'd5, 32'd7, 32'h1, 8, 32'd12, 32'h40);
    wait_done("basic", 32'd5, 32'd7, 32'h1, 8, 32'd12, 32'h40, 0, 0);

    // window=0 skips RUN
    @(negedge clk);
    launch(32'hA, 32'hB, 32'h2, 0, 32'h15, 32'h0);
    wait_done("win0", 32'hA, 32'hB, 32'h2, 0, 32'h15, 32'h0, 0, 0);

    // start spammed while busy: one done, no relatch
    @(negedge clk);
    launch(32'h100, 32'h200, 32'hF0, 6, 32'h300, 32'h77);
    wait_done("spam", 32'h100, 32'h200, 32'hF0, 6, 32'h300, 32'h77, 1, 0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("spam_no_extra", 64'(extra), 64'(0));

    // Wrap-around operands: correct sum, then wrong sum
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'h1, 32'h8, 3, 32'h0, 32'hFFFF_FFFF);
    wait_done("wrap_ok", 32'hFFFF_FFFF, 32'h1, 32'h8, 3, 32'h0, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'h1, 32'h8, 3, 32'h1, 32'h5);
    wait_done("wrap_bad", 32'hFFFF_FFFF, 32'h1, 32'h8, 3, 32'h1, 32'h5, 0, 0);

    // Back-to-back with start held: second LOAD the cycle after done
    @(negedge clk);
    launch(32'h1234, 32'h4321, 32'h55, 2, 32'h5555, 32'h10);
    wait_done("b2b_first", 32'h1234, 32'h4321, 32'h55, 2, 32'h5555, 32'h10, 0, 1);
    launch(32'hBEEF, 32'hCAFE, 32'hAA, 5, 32'h1, 32'h20);
    wait_done("b2b_second", 32'hBEEF, 32'hCAFE, 32'hAA, 5, 32'h1, 32'h20, 0, 0);

    // Randomized measurements against the timing/result model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rr = $urandom;
      rw = $urandom_range(0, 12);
      rs = ($urandom_range(0, 1) == 1) ? ra + rb : $urandom;
      rc = $urandom;
      @(negedge clk);
      launch(ra, rb, rr, rw, rs, rc);
      wait_done("rand", ra, rb, rr, rw, rs, rc, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
